// File: rtl/da_fir_pkg.sv
// Shared constants and FSM state type for the distributed-arithmetic FIR engine.
package da_fir_pkg;
    localparam int DATA_W_DEF    = 12;
    localparam int TAPS_DEF      = 7;
    localparam int OPSIZE_DEF    = 12;
    localparam int ADDR_SIZE_DEF = 8;
    localparam int ACC_W_DEF     = OPSIZE_DEF + DATA_W_DEF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } fir_state_e;
endpackage

// File: rtl/da_fir_engine_if.sv
// Sample-in / result-out handshakes plus the external coefficient ROM port.
interface da_fir_engine_if
    import da_fir_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int OPSIZE    = OPSIZE_DEF,
    parameter int ADDR_SIZE = ADDR_SIZE_DEF,
    parameter int ACC_W     = ACC_W_DEF
);
    logic [DATA_W-1:0]    i_x;
    logic                 i_x_valid;
    logic                 o_x_ready;
    logic                 o_rom_oe;
    logic [ADDR_SIZE-1:0] o_rom_addr;
    logic [OPSIZE-1:0]    i_rom_data;
    logic [ACC_W-1:0]     o_y;
    logic                 o_y_valid;
    logic                 i_y_ready;

    // Engine side: consumes samples and ROM words, produces results.
    modport slave (
        input  i_x, i_x_valid, i_rom_data, i_y_ready,
        output o_x_ready, o_rom_oe, o_rom_addr, o_y, o_y_valid
    );

    // Host side: feeds samples, models the ROM, drains results.
    modport master (
        output i_x, i_x_valid, i_rom_data, i_y_ready,
        input  o_x_ready, o_rom_oe, o_rom_addr, o_y, o_y_valid
    );
endinterface

// File: rtl/da_tap_line.sv
// Sample delay line plus bit-slice selector forming the DA ROM address.
module da_tap_line #(
    parameter int DATA_W    = 12,
    parameter int TAPS      = 7,
    parameter int ADDR_SIZE = 8,
    parameter int BW        = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 shift,
    input  logic [DATA_W-1:0]    x,
    input  logic [BW-1:0]        bit_sel,
    output logic [ADDR_SIZE-1:0] addr
);
    logic [TAPS-1:0][DATA_W-1:0] taps;

    for (genvar k = 0; k < TAPS; k++) begin : g_tap
        if (k == 0) begin : g_head
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)     taps[0] <= '0;
                else if (shift) taps[0] <= x;
            end
        end else begin : g_body
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)     taps[k] <= '0;
                else if (shift) taps[k] <= taps[k-1];
            end
        end
    end

    // Address bit k is bit 'bit_sel' of tap k; unused upper address bits stay 0.
    always_comb begin
        addr = '0;
        for (int k = 0; k < TAPS; k++) begin
            addr[k] = taps[k][bit_sel];
        end
    end
endmodule

// File: rtl/da_fir_engine.sv
// Bit-serial distributed-arithmetic FIR: one ROM lookup per input bit, shift-accumulate.
module da_fir_engine
    import da_fir_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int TAPS      = TAPS_DEF,
    parameter int OPSIZE    = OPSIZE_DEF,
    parameter int ADDR_SIZE = ADDR_SIZE_DEF,
    parameter int ACC_W     = OPSIZE + DATA_W
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    da_fir_engine_if.slave    bus
);
    localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    fir_state_e           state;
    logic [BW-1:0]        b;
    logic [ACC_W-1:0]     acc;
    logic [ACC_W-1:0]     term;
    logic [ADDR_SIZE-1:0] slice_addr;
    logic                 accept;
    logic                 last;

    assign accept = (state == ST_IDLE) && bus.i_x_valid;
    assign last   = (b == BW'(DATA_W - 1));
    assign term   = {{(ACC_W-OPSIZE){bus.i_rom_data[OPSIZE-1]}}, bus.i_rom_data} << b;

    da_tap_line #(
        .DATA_W    (DATA_W),
        .TAPS      (TAPS),
        .ADDR_SIZE (ADDR_SIZE),
        .BW        (BW)
    ) u_tap_line (
        .clk     (i_clk),
        .rst_n   (i_rst_n),
        .shift   (accept),
        .x       (bus.i_x),
        .bit_sel (b),
        .addr    (slice_addr)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= ST_IDLE;
            acc   <= '0;
            b     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        acc   <= '0;
                        b     <= '0;
                        state <= ST_ACCUM;
                    end
                end
                ST_ACCUM: begin
                    // The sign bit slice carries weight -2^(DATA_W-1), hence subtract.
                    acc <= last ? (acc - term) : (acc + term);
                    if (last) begin
                        b     <= '0;
                        state <= ST_DONE;
                    end else begin
                        b <= b + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (bus.i_y_ready) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.o_x_ready  = (state == ST_IDLE);
    assign bus.o_rom_oe   = (state == ST_ACCUM);
    assign bus.o_rom_addr = (state == ST_ACCUM) ? slice_addr : '0;
    assign bus.o_y_valid  = (state == ST_DONE);
    assign bus.o_y        = acc;
endmodule

// File: tb/tb_da_fir_engine.sv
// Directed scoreboard bench for da_fir_engine with h = 1..7 coefficient ROM.
module tb_da_fir_engine;
    localparam int DATA_W    = 12;
    localparam int TAPS      = 7;
    localparam int OPSIZE    = 12;
    localparam int ADDR_SIZE = 8;
    localparam int ACC_W     = 24;

    logic i_clk   = 1'b0;
    logic i_rst_n = 1'b0;
    always #5 i_clk = ~i_clk;

    da_fir_engine_if #(.DATA_W(DATA_W), .OPSIZE(OPSIZE), .ADDR_SIZE(ADDR_SIZE), .ACC_W(ACC_W)) bus ();

    da_fir_engine #(
        .DATA_W(DATA_W), .TAPS(TAPS), .OPSIZE(OPSIZE), .ADDR_SIZE(ADDR_SIZE), .ACC_W(ACC_W)
    ) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .bus     (bus)
    );

    function automatic logic [OPSIZE-1:0] rom_word(input logic [ADDR_SIZE-1:0] a);
        int s = 0;
        for (int k = 0; k < TAPS; k++) if (a[k]) s += k + 1;
        return OPSIZE'(s);
    endfunction

    assign bus.i_rom_data = bus.o_rom_oe ? rom_word(bus.o_rom_addr) : '0;

    typedef struct {
        logic signed [ACC_W-1:0] y;
        int                      due;
    } exp_t;

    exp_t q[$];
    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    logic signed [DATA_W-1:0] mtap [TAPS];

    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Result monitor: latency on each rising o_y_valid, value on each handshake.
    logic prev_v = 1'b0;
    always @(negedge i_clk) begin
        #2;
        if (bus.o_y_valid && !prev_v) begin
            if (q.size() == 0) chk("spurious_y_valid", 1, 0);
            else               chk("latency", cyc, q[0].due);
        end
        if (bus.o_y_valid && bus.i_y_ready && q.size() > 0) begin
            chk("y", $signed(bus.o_y), q[0].y);
            void'(q.pop_front());
        end
        prev_v = bus.o_y_valid;
    end

    task automatic send(input logic signed [DATA_W-1:0] x, output int acc_edge);
        int n = 0;
        exp_t e;
        logic signed [63:0] s;
        acc_edge = -1;
        bus.i_x = x;
        bus.i_x_valid = 1'b1;
        while (!bus.o_x_ready) begin
            if (n == 200) begin
                chk("x_ready_timeout", 0, 1);
                bus.i_x_valid = 1'b0;
                return;
            end
            @(negedge i_clk);
            n++;
        end
        acc_edge = cyc + 1;
        for (int k = TAPS - 1; k > 0; k--) mtap[k] = mtap[k-1];
        mtap[0] = x;
        s = 0;
        for (int k = 0; k < TAPS; k++) s += 64'(k + 1) * 64'(mtap[k]);
        e.y   = s[ACC_W-1:0];
        e.due = acc_edge + DATA_W;
        q.push_back(e);
        @(negedge i_clk);
        bus.i_x_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (q.size() != 0 && n < 300) begin
            @(negedge i_clk);
            n++;
        end
        chk(tag, q.size(), 0);
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!bus.o_y_valid && n < 100) begin
            @(negedge i_clk);
            n++;
        end
        if (!bus.o_y_valid) chk("y_valid_timeout", 0, 1);
    endtask

    initial begin
        int e;
        int hs;
        int cnt;
        logic signed [ACC_W-1:0] held;
        logic [ADDR_SIZE-1:0] exp_addr;

        bus.i_x = '0;
        bus.i_x_valid = 1'b0;
        bus.i_y_ready = 1'b1;
        for (int k = 0; k < TAPS; k++) mtap[k] = '0;

        repeat (3) @(negedge i_clk);
        i_rst_n = 1'b1;
        #1;
        chk("rst_x_ready", bus.o_x_ready, 1);
        chk("rst_y_valid", bus.o_y_valid, 0);
        chk("rst_rom_oe", bus.o_rom_oe, 0);
        chk("rst_rom_addr", bus.o_rom_addr, 0);
        @(negedge i_clk);

        // Impulse response, plus one trailing zero output
        send(12'sd1, e);
        repeat (7) send(12'sd0, e);
        drain("drain_impulse");

        // Negative full-scale impulse exercises the sign-bit subtract
        send(-12'sd2048, e);
        repeat (6) send(12'sd0, e);
        drain("drain_negimp");

        repeat (6) send(12'sd2047, e);
        drain("drain_pos_pre");
        send(12'sd2047, e);
        wait_valid();
        chk("pos_full_scale", $signed(bus.o_y), 57316);
        drain("drain_pos");

        repeat (6) send(-12'sd2048, e);
        drain("drain_neg_pre");
        send(-12'sd2048, e);
        wait_valid();
        chk("neg_full_scale", $signed(bus.o_y), -57344);
        drain("drain_neg");

        // Backpressure in DONE with a new sample pending
        bus.i_y_ready = 1'b0;
        send(12'sd5, e);
        wait_valid();
        held = q[0].y;
        bus.i_x = -12'sd3;
        bus.i_x_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("bp_y_hold", $signed(bus.o_y), held);
            chk("bp_y_valid", bus.o_y_valid, 1);
            chk("bp_x_ready", bus.o_x_ready, 0);
            @(negedge i_clk);
        end
        bus.i_y_ready = 1'b1;
        hs = cyc + 1;
        send(-12'sd3, e);
        chk("bp_accept_edge", e, hs + 1);
        drain("drain_bp");

        // Reset in the middle of ACCUM at bit 5
        send(12'sd9, e);
        repeat (5) @(negedge i_clk);
        exp_addr = '0;
        for (int k = 0; k < TAPS; k++) exp_addr[k] = mtap[k][5];
        chk("accum_rom_oe", bus.o_rom_oe, 1);
        chk("accum_rom_addr", bus.o_rom_addr, exp_addr);
        i_rst_n = 1'b0;
        #1;
        chk("midrst_y_valid", bus.o_y_valid, 0);
        chk("midrst_rom_oe", bus.o_rom_oe, 0);
        chk("midrst_rom_addr", bus.o_rom_addr, 0);
        q.delete();
        for (int k = 0; k < TAPS; k++) mtap[k] = '0;
        @(negedge i_clk);
        i_rst_n = 1'b1;
        #1;
        chk("midrst_x_ready", bus.o_x_ready, 1);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge i_clk);
            if (bus.o_y_valid) cnt++;
        end
        chk("midrst_no_valid", cnt, 0);
        send(12'sd1, e);
        wait_valid();
        chk("post_rst_impulse", $signed(bus.o_y), 1);
        drain("drain_post_rst");

        repeat (3) @(negedge i_clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/da_fir_engine.md
DA_FIR_ENGINE -- requirements
Module: da_fir_engine

Interface
REQ-001 Parameter DATA_W, default 12: input sample width, signed two's complement, processed bit-serially.
REQ-002 Parameter TAPS, default 7: filter length; one ROM address bit per tap; TAPS <= ADDR_SIZE.
REQ-003 Parameter OPSIZE, default 12: ROM word width, signed partial-sum of coefficients.
REQ-004 Parameter ADDR_SIZE, default 8: ROM address width.
REQ-005 Parameter ACC_W, default OPSIZE+DATA_W: accumulator and result width.
REQ-006 One clock; reset is asynchronous and active-low: i_clk input 1 rising-edge clock; i_rst_n input 1 async active-low reset.
REQ-007 i_x  input  DATA_W  new input sample.
REQ-008 i_x_valid  input  1  i_x valid.
REQ-009 o_x_ready  output  1  engine accepts a sample this cycle.
REQ-010 o_rom_oe  output  1  ROM output enable.
REQ-011 o_rom_addr  output  ADDR_SIZE  ROM address.
REQ-012 i_rom_data  input  OPSIZE  ROM word, combinational response to o_rom_addr in the same cycle.
REQ-013 o_y  output  ACC_W  filter result, signed.
REQ-014 o_y_valid  output  1  o_y valid.
REQ-015 i_y_ready  input  1  downstream accepts o_y.

Function
REQ-016 The FSM SHALL have states IDLE, ACCUM, DONE.
REQ-017 IDLE: o_x_ready=1; sample accepted on i_x_valid&&o_x_ready; tap line shifts (tap0<=i_x, tapk<=tap(k-1), oldest dropped), accumulator<=0, bit counter b<=0, next state ACCUM.
REQ-018 o_x_ready SHALL be 0 in ACCUM and DONE; samples presented there are held off, never dropped.
REQ-019 ACCUM: o_rom_oe=1; o_rom_addr[k]=tapk[b] for k<TAPS, upper bits 0; each cycle acc<=acc+(sext(i_rom_data)<<b) for b<DATA_W-1, acc<=acc-(sext(i_rom_data)<<b) at b=DATA_W-1 (sign bit).
REQ-020 ACCUM SHALL last exactly DATA_W cycles, b counting 0..DATA_W-1, then DONE.
REQ-021 Outside ACCUM, o_rom_oe=0 and o_rom_addr=0.
REQ-022 DONE: o_y_valid=1, o_y=acc, held stable until i_y_ready=1; on handshake next state IDLE, o_y_valid=0 next cycle.
REQ-023 Result SHALL equal sum over k of h_k*tapk exactly (ROM[a]=sum of h_k with a[k]=1), arithmetic modulo 2^ACC_W.
REQ-024 Latency: sample accepted at edge N, o_y_valid high from edge N+DATA_W; max throughput one sample per DATA_W+2 cycles.
REQ-025 Tap line SHALL persist across samples; only reset clears it.

Reset
REQ-026 On i_rst_n=0, immediately: state IDLE, all taps 0, acc 0, b 0, o_y_valid 0, o_rom_oe 0, o_rom_addr 0; o_x_ready 1 once released.
REQ-027 Reset mid-ACCUM or mid-DONE SHALL discard the in-flight result; no o_y_valid pulse follows.

Structure
REQ-028 Package da_fir_pkg SHALL hold the FSM state enum typedef and default parameter constants.
REQ-029 Sub-module da_tap_line SHALL hold the TAPS x DATA_W shift register and the bit-slice address mux.
REQ-030 ROM stays external; engine connects to its i_oe/i_addr/o_data.

Verification (TAPS=7, DATA_W=12, ROM built from h=[1,2,3,4,5,6,7])
REQ-031 Reset release -> o_x_ready=1, o_y_valid=0, o_rom_oe=0, o_rom_addr=0.
REQ-032 Impulse x=1 then six zeros, i_y_ready=1 -> o_y sequence 1,2,3,4,5,6,7, then 0; each o_y_valid 12 cycles after acceptance.
REQ-033 x=0x800 (-2048) then zeros -> o_y sequence -2048,-4096,...,-14336.
REQ-034 Seven samples of 2047 -> 7th o_y=57316; seven of -2048 -> -57344.
REQ-035 i_y_ready low 5 cycles in DONE with i_x_valid high -> o_y stable, o_x_ready=0, sample accepted only after handshake and return to IDLE.
REQ-036 Reset asserted at b=5 of ACCUM -> no o_y_valid; then impulse x=1 -> first o_y=1.
